// File: rtl/mod_reduce_25519.sv
`default_nettype none
// ============================================================================
// Module      : mod_reduce_25519
// Description : Sequential reduction of a 512-bit unsigned product modulo
//               p = 2^255 - 19. Three folding passes (2^256 = 38, 2^255 = 19)
//               followed by one conditional subtraction of p.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_ready - input handshake, prod [2N-1:0]
//               out_valid/out_ready - output handshake, res [N-1:0]
//               busy              - high whenever the FSM is not idle
//               done_cnt [15:0]   - completed-handshake counter, present only
//                                   when macro MODRED_CNT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module mod_reduce_25519 #(
  parameter int N = 256  // operand width; only 256 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     res,
  output logic             busy
`ifdef MODRED_CNT_EN
  ,
  output logic [15:0]      done_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FOLD1 = 3'd1,
    FOLD2 = 3'd2,
    FOLD3 = 3'd3,
    SUB   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  state_t state;

  // The accumulator must hold the raw product on load; after the first fold
  // the value fits in 263 bits and the upper bits stay zero.
  logic [2*N-1:0] acc;

  logic [262:0] fold1_sum;
  logic [255:0] fold2_sum;
  logic [255:0] fold3_sum;
  logic [255:0] sub_res;

  // acc[255:0] + 38*acc[511:256] < 39*2^256 < 2^262: no overflow in 263 bits.
  assign fold1_sum = 263'(acc[255:0]) + 263'(acc[511:256]) * 263'(38);
  // acc[254:0] + 19*acc[262:255] < 2^255 + 4845: fits in 256 bits.
  assign fold2_sum = 256'(acc[254:0]) + 256'(acc[262:255]) * 256'(19);
  // If bit 255 is set the low part is below 4845, so the result is < 2^255.
  assign fold3_sum = 256'(acc[254:0]) + (acc[255] ? 256'd19 : 256'd0);
  // Input here is < 2^255 < 2p, so a single subtraction is enough.
  assign sub_res   = (acc[255:0] >= P) ? (acc[255:0] - P) : acc[255:0];

  assign res = N'(acc[254:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= prod;
            state    <= FOLD1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FOLD1: begin
          acc   <= (2*N)'(fold1_sum);
          state <= FOLD2;
        end
        FOLD2: begin
          acc   <= (2*N)'(fold2_sum);
          state <= FOLD3;
        end
        FOLD3: begin
          acc   <= (2*N)'(fold3_sum);
          state <= SUB;
        end
        SUB: begin
          acc       <= (2*N)'(sub_res);
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MODRED_CNT_EN
  // Free-running count of completed output handshakes; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= 16'd0;
    end else if (state == DONE && out_ready) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_reduce_25519.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_reduce_25519
// Description : Directed self-checking bench for mod_reduce_25519. Exercises
//               reset values, latency, directed reduction vectors, boundary
//               inputs, backpressure, mid-operation reset and back-to-back
//               spacing. Counter checks are included when MODRED_CNT_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_reduce_25519;

  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] prod = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] res;
  logic         busy;
`ifdef MODRED_CNT_EN
  logic [15:0]  done_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_reduce_25519 #(.N(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
`ifdef MODRED_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer one product, check latency and result; keep out_ready low for
  // 'hold' cycles in DONE before completing the handshake.
  task automatic run(input string tag, input logic [511:0] p,
                     input logic [255:0] exp, input int hold);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, 256'(in_ready), 256'd1);
    prod      = p;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    prod     = '0;
    check({tag, "_busy"}, 256'(busy), 256'd1);
    n = 0;
    while (n < 10) begin
      n++;
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 256'(n), 256'd4);
    check({tag, "_res"}, res, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 256'(out_valid), 256'd1);
      check({tag, "_hold_res"}, res, exp);
      check({tag, "_hold_in_ready"}, 256'(in_ready), 256'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 256'(out_valid), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ones;
    int first_acc;
    int second_acc;
    int cyc;
    ones = '1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'd1);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_res", res, 256'd0);

    // Transfer offered while reset is asserted must be ignored
    prod     = 512'd123;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_xfer_busy", 256'(busy), 256'd0);
    check("rst_xfer_in_ready", 256'(in_ready), 256'd1);
    in_valid = 1'b0;
    rst      = 1'b0;

    // Directed vectors
    run("small60", 512'd60, 256'd60, 0);
    run("max_sq", 512'(ones) * 512'(ones), 256'd1369, 0);
    run("pow255", 512'd1 << 255, 256'd19, 0);
    run("two_p", (512'd1 << 256) - 512'd38, 256'd0, 0);
    run("p_m1", 512'(P) - 512'd1, P - 256'd1, 0);
    run("p", 512'(P), 256'd0, 0);
    run("zero", 512'd0, 256'd0, 0);
    run("pow256", 512'd1 << 256, 256'd38, 0);
    run("all_ones", '1, 256'd1443, 0);

    // Backpressure: three stalled DONE cycles, handshake on the fourth
    run("bp", 512'd99, 256'd99, 3);

    // Reset during FOLD2
    @(negedge clk);
    prod     = '1;
    in_valid = 1'b1;
    @(posedge clk);          // accept -> FOLD1
    #1;
    in_valid = 1'b0;
    @(posedge clk);          // -> FOLD2
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 256'(out_valid), 256'd0);
    check("midrst_in_ready", 256'(in_ready), 256'd1);
    check("midrst_busy", 256'(busy), 256'd0);
    run("after_rst5", 512'd5, 256'd5, 0);

    // Back-to-back spacing with in_valid and out_ready held high
    @(negedge clk);
    prod       = 512'd7;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    first_acc  = -1;
    second_acc = -1;
    cyc        = 0;
    while (cyc < 20 && second_acc < 0) begin
      if (in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        else second_acc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_spacing", 256'(second_acc - first_acc), 256'd6);
    // let the second operation drain
    repeat (8) @(negedge clk);
    check("b2b_res", res, 256'd7);

`ifdef MODRED_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cnt_reset", 256'(done_cnt), 256'd0);
    run("cnt1", 512'd1, 256'd1, 0);
    run("cnt2", 512'd2, 256'd2, 0);
    run("cnt3", 512'd3, 256'd3, 1);
    check("cnt_three", 256'(done_cnt), 256'd3);
    @(negedge clk);
    force dut.done_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.done_cnt;
    check("cnt_preset", 256'(done_cnt), 256'hFFFF);
    run("cnt_wrap", 512'd4, 256'd4, 0);
    check("cnt_wrap_zero", 256'(done_cnt), 256'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
